// File: rtl/grng_burst_ctrl.sv
// Burst controller for a Gaussian RNG: discards pipeline warm-up, round-robin
// grants two requesters, and streams len samples per grant through a small FIFO.
module grng_burst_ctrl #(
    parameter int WARMUP = 8,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] grng_sample,
    input  logic [1:0]  req,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        out_id
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    typedef enum logic [1:0] {WARM, IDLE, BURST, DRAIN} state_t;

    typedef struct packed {
        logic        last;
        logic        id;
        logic [15:0] data;
    } entry_t;

    state_t          state;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic [8:0]      remaining;
    logic [CW-1:0]   warm_cnt;
    logic            last_gnt, own_id;
    logic            push, pop, win_id;
    logic [7:0]      win_len;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr].data;
    assign out_last  = mem[rd_ptr].last;
    assign out_id    = mem[rd_ptr].id;

    assign pop  = out_valid && out_ready;
    // Full blocks the push even when a pop frees a slot on the same edge.
    assign push = (state == BURST) && (remaining != '0) && (count != FULL);

    // Requester 1 wins when alone, or when both ask and 0 had the last grant.
    assign win_id  = req[1] && (!req[0] || !last_gnt);
    assign win_len = win_id ? len1 : len0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WARM;
            busy      <= 1'b1;
            grant     <= 2'b00;
            warm_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            last_gnt  <= 1'b1;
            own_id    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            grant <= 2'b00;
            case (state)
                WARM: begin
                    if (warm_cnt == CW'(WARMUP - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + CW'(1);
                    end
                end
                IDLE: begin
                    if (req != 2'b00) begin
                        state     <= BURST;
                        busy      <= 1'b1;
                        grant     <= win_id ? 2'b10 : 2'b01;
                        last_gnt  <= win_id;
                        own_id    <= win_id;
                        remaining <= (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
                    end
                end
                BURST: begin
                    if (push && remaining == 9'd1) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= WARM;
            endcase

            if (push) begin
                mem[wr_ptr] <= '{last: (remaining == 9'd1), id: own_id, data: grng_sample};
                wr_ptr      <= wr_ptr + AW'(1);
                remaining   <= remaining - 9'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_grng_burst_ctrl.sv
// Self-checking bench for grng_burst_ctrl: reference scoreboard checked every
// cycle, a table of grant/burst vectors, and directed warm-up/stall/reset cases.
module tb_grng_burst_ctrl;

    localparam int WARMUP = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] grng_sample = 16'h1234;
    logic [1:0]  req = 2'b00;
    logic [7:0]  len0 = 8'd0, len1 = 8'd0;
    logic        out_ready = 1'b1;
    logic [1:0]  grant;
    logic        busy, out_valid, out_last, out_id;
    logic [15:0] out_data;

    grng_burst_ctrl #(.WARMUP(WARMUP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .grng_sample(grng_sample), .req(req),
        .len0(len0), .len1(len1), .grant(grant), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_id(out_id)
    );

    always #5 clk = ~clk;

    // Generator: a new, distinct signed value each cycle.
    initial forever begin
        @(negedge clk);
        grng_sample = grng_sample + 16'h9E37;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        id;
    } ent_t;

    ent_t       q[$];
    int         mstate = 0;  // 0 WARM, 1 IDLE, 2 BURST, 3 DRAIN
    int         mwarm = 0, mrem = 0;
    logic       mlast_g = 1'b1, mid = 1'b0, mbusy = 1'b1;
    logic [1:0] mgrant = 2'b00;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            q.delete();
            mstate = 0; mwarm = 0; mrem = 0; mlast_g = 1'b1; mid = 1'b0;
            mgrant = 2'b00; mbusy = 1'b1;
        end else begin
            bit   pop, pl, push, w;
            logic [7:0] l;
            pop  = out_ready && (q.size() != 0);
            pl   = pop && q[0].l;
            push = (mstate == 2) && (mrem > 0) && (q.size() < DEPTH);
            mgrant = 2'b00;
            case (mstate)
                0: if (mwarm == WARMUP - 1) mstate = 1; else mwarm++;
                1: if (req != 2'b00) begin
                    w = (req == 2'b10) || (req == 2'b11 && !mlast_g);
                    mgrant = w ? 2'b10 : 2'b01;
                    mlast_g = w; mid = w;
                    l = w ? len1 : len0;
                    mrem = (l == 8'd0) ? 256 : int'(l);
                    mstate = 2;
                end
                2: if (push && mrem == 1) mstate = 3;
                default: if (pl) mstate = 1;
            endcase
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{grng_sample, (mrem == 1), mid});
                mrem--;
            end
            mbusy = (mstate != 1);
        end
    end

    int          n_deliv = 0, n_last = 0, last_pos = 0;
    logic        last_id = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d = '0;

    // Per-cycle checker, sampled well away from the rising edge.
    initial forever begin
        @(negedge clk); #2;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(mbusy));
            chk("grant", 32'(grant), 32'(mgrant));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(q[0].d));
                chk("out_last", 32'(out_last), 32'(q[0].l));
                chk("out_id", 32'(out_id), 32'(q[0].id));
            end
            if (prev_stall) chk("hold_data", 32'(out_data), 32'(prev_d));
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (out_valid && out_ready) begin
                n_deliv++;
                if (out_last) begin
                    n_last++;
                    last_pos = n_deliv;
                    last_id  = out_id;
                end
            end
        end
    end

    task automatic step;
        @(negedge clk); #1;
    endtask

    task automatic clr_counts;
        n_deliv = 0; n_last = 0; last_pos = 0; last_id = 1'b0;
    endtask

    // Warm-up after release: requests are ignored and busy drops on edge WARMUP.
    task automatic warm_check;
        req = 2'b11;
        for (int k = 1; k <= WARMUP; k++) begin
            step;
            chk("warm_busy", 32'(busy), 32'(k < WARMUP));
            chk("warm_grant", 32'(grant), 32'd0);
            if (k == WARMUP) req = 2'b00;
        end
    endtask

    task automatic wait_idle(input bit rnd);
        int c;
        for (c = 0; busy && c < 3000; c++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [7:0] l0, l1;
        logic [1:0] g;
        logic       id;
        int         n;
        bit         rnd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{2'b10, 8'd0, 8'd3, 2'b10, 1'b1, 3,   1'b0};
        tbl[1] = '{2'b11, 8'd2, 8'd2, 2'b01, 1'b0, 2,   1'b0};
        tbl[2] = '{2'b11, 8'd2, 8'd2, 2'b10, 1'b1, 2,   1'b0};
        tbl[3] = '{2'b10, 8'd9, 8'd0, 2'b10, 1'b1, 256, 1'b0};
        tbl[4] = '{2'b11, 8'd7, 8'd1, 2'b01, 1'b0, 7,   1'b1};
        tbl[5] = '{2'b01, 8'd1, 8'd5, 2'b01, 1'b0, 1,   1'b1};
        tbl[6] = '{2'b11, 8'd4, 8'd3, 2'b10, 1'b1, 3,   1'b1};
        tbl[7] = '{2'b10, 8'd6, 8'd9, 2'b10, 1'b1, 9,   1'b1};

        // Reset values
        repeat (3) step;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        reset = 1'b1;
        warm_check;

        // Single 5-sample burst with exact latency
        clr_counts;
        step;
        req = 2'b01; len0 = 8'd5;
        step;
        chk("b5_grant", 32'(grant), 32'b01);
        chk("b5_valid_e", 32'(out_valid), 32'd0);
        req = 2'b00;
        step;
        chk("b5_grant_off", 32'(grant), 32'd0);
        chk("b5_valid_e1", 32'(out_valid), 32'd1);
        begin
            int c;
            for (c = 0; busy && c < 50; c++) step;
            chk("b5_busy_fall", 32'(c), 32'd5);
        end
        chk("b5_count", 32'(n_deliv), 32'd5);
        chk("b5_lastpos", 32'(last_pos), 32'd5);
        chk("b5_nlast", 32'(n_last), 32'd1);
        chk("b5_id", 32'(last_id), 32'd0);

        // Grant/length table
        for (int i = 0; i < 8; i++) begin
            clr_counts;
            step;
            req = tbl[i].rq; len0 = tbl[i].l0; len1 = tbl[i].l1;
            step;
            chk($sformatf("t%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            req = 2'b00;
            wait_idle(tbl[i].rnd);
            chk($sformatf("t%0d_count", i), 32'(n_deliv), 32'(tbl[i].n));
            chk($sformatf("t%0d_lastpos", i), 32'(last_pos), 32'(tbl[i].n));
            chk($sformatf("t%0d_nlast", i), 32'(n_last), 32'd1);
            chk($sformatf("t%0d_id", i), 32'(last_id), 32'(tbl[i].id));
            chk($sformatf("t%0d_idle_valid", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: 20 stalled cycles, then drain all 10
        clr_counts;
        step;
        req = 2'b01; len0 = 8'd10; out_ready = 1'b0;
        step;
        chk("st_grant", 32'(grant), 32'b01);
        req = 2'b00;
        step;
        begin
            logic [15:0] hold;
            hold = out_data;
            for (int i = 0; i < 19; i++) begin
                step;
                chk("st_valid", 32'(out_valid), 32'd1);
                chk("st_hold", 32'(out_data), 32'(hold));
                chk("st_busy", 32'(busy), 32'd1);
            end
        end
        chk("st_none", 32'(n_deliv), 32'd0);
        out_ready = 1'b1;
        wait_idle(1'b0);
        chk("st_count", 32'(n_deliv), 32'd10);
        chk("st_lastpos", 32'(last_pos), 32'd10);

        // Reset after the third sample of a 10-sample burst
        clr_counts;
        step;
        req = 2'b01; len0 = 8'd10;
        step;
        req = 2'b00;
        begin
            int c;
            for (c = 0; n_deliv < 3 && c < 100; c++) step;
            chk("rb_reach3", 32'(n_deliv), 32'd3);
        end
        reset = 1'b0;
        #1;
        chk("rb_valid", 32'(out_valid), 32'd0);
        chk("rb_busy", 32'(busy), 32'd1);
        chk("rb_data", 32'(out_data), 32'd0);
        chk("rb_last", 32'(out_last), 32'd0);
        step; step;
        reset = 1'b1;
        warm_check;
        clr_counts;
        step;
        req = 2'b11; len0 = 8'd4; len1 = 8'd6;
        step;
        chk("rb_grant", 32'(grant), 32'b01);
        req = 2'b00;
        wait_idle(1'b0);
        chk("rb_count", 32'(n_deliv), 32'd4);
        chk("rb_lastpos", 32'(last_pos), 32'd4);
        chk("rb_id", 32'(last_id), 32'd0);

        step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
